// File: rtl/alu_arbiter_if.sv
//------------------------------------------------------------------------------
// Module : alu_arbiter_if
// Bundle of requester, ALU and response signals for the shared-ALU arbiter.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface alu_arbiter_if #(
    parameter int NUM_REQ = 2
);
    localparam int IDW = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_ready;
    logic [NUM_REQ*32-1:0] req_in1;
    logic [NUM_REQ*32-1:0] req_in2;
    logic [NUM_REQ*3-1:0]  req_op;

    logic [31:0]           alu_in1;
    logic [31:0]           alu_in2;
    logic [2:0]            alu_op;
    logic [31:0]           alu_out;
    logic                  zero;
    logic                  less_than;
    logic                  less_than_unsigned;

    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [IDW-1:0]        rsp_id;
    logic [31:0]           rsp_data;
    logic                  rsp_zero;
    logic                  rsp_lt;
    logic                  rsp_ltu;

    // Arbiter side
    modport slave (
        input  req_valid, req_in1, req_in2, req_op,
        input  alu_out, zero, less_than, less_than_unsigned,
        input  rsp_ready,
        output req_ready,
        output alu_in1, alu_in2, alu_op,
        output rsp_valid, rsp_id, rsp_data, rsp_zero, rsp_lt, rsp_ltu
    );

    // Requesters, ALU and response consumer side
    modport master (
        output req_valid, req_in1, req_in2, req_op,
        output alu_out, zero, less_than, less_than_unsigned,
        output rsp_ready,
        input  req_ready,
        input  alu_in1, alu_in2, alu_op,
        input  rsp_valid, rsp_id, rsp_data, rsp_zero, rsp_lt, rsp_ltu
    );
endinterface

`default_nettype wire

// File: rtl/alu_arbiter.sv
//------------------------------------------------------------------------------
// Module : alu_arbiter
// Round-robin sharing of one combinational ALU with a one-entry response slot.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module alu_arbiter #(
    parameter int NUM_REQ = 2
) (
    input  wire logic     clk,
    input  wire logic     rst_n,
    alu_arbiter_if.slave  bus
);
    localparam int IDW = $clog2(NUM_REQ);

    typedef enum logic [0:0] {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;

    logic [IDW-1:0] r_ptr;
    logic [IDW-1:0] w_ptr_nxt;
    logic [IDW-1:0] w_gidx;
    logic [IDW-1:0] w_idx;
    logic           w_found;
    logic           w_slot_free;
    logic           w_grant;

    logic [IDW-1:0] r_rsp_id;
    logic [31:0]    r_rsp_data;
    logic           r_rsp_zero;
    logic           r_rsp_lt;
    logic           r_rsp_ltu;

    assign w_slot_free = (r_state == EMPTY) || bus.rsp_ready;

    // Search from the pointer upward, wrapping, for the first active requester
    always_comb begin
        w_found = 1'b0;
        w_gidx  = '0;
        w_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_idx = IDW'((int'(r_ptr) + k) % NUM_REQ);
            if (!w_found && bus.req_valid[w_idx]) begin
                w_found = 1'b1;
                w_gidx  = w_idx;
            end
        end
    end

    // rst_n gating keeps req_ready low combinationally while in reset
    assign w_grant   = w_found && w_slot_free && rst_n;
    assign w_ptr_nxt = (w_gidx == IDW'(NUM_REQ - 1)) ? '0 : w_gidx + 1'b1;

    assign bus.req_ready = w_grant ? (NUM_REQ'(1) << w_gidx) : '0;
    assign bus.alu_in1   = w_grant ? bus.req_in1[32*w_gidx +: 32] : 32'd0;
    assign bus.alu_in2   = w_grant ? bus.req_in2[32*w_gidx +: 32] : 32'd0;
    assign bus.alu_op    = w_grant ? bus.req_op[3*w_gidx +: 3]    : 3'd0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_grant) begin
            w_state_nxt = FULL;
        end else if ((r_state == FULL) && bus.rsp_ready) begin
            w_state_nxt = EMPTY;
        end
    end

    // The ALU is combinational, so its outputs already reflect the granted operands
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr      <= '0;
            r_rsp_id   <= '0;
            r_rsp_data <= 32'd0;
            r_rsp_zero <= 1'b0;
            r_rsp_lt   <= 1'b0;
            r_rsp_ltu  <= 1'b0;
        end else if (w_grant) begin
            r_ptr      <= w_ptr_nxt;
            r_rsp_id   <= w_gidx;
            r_rsp_data <= bus.alu_out;
            r_rsp_zero <= bus.zero;
            r_rsp_lt   <= bus.less_than;
            r_rsp_ltu  <= bus.less_than_unsigned;
        end
    end

    assign bus.rsp_valid = (r_state == FULL);
    assign bus.rsp_id    = r_rsp_id;
    assign bus.rsp_data  = r_rsp_data;
    assign bus.rsp_zero  = r_rsp_zero;
    assign bus.rsp_lt    = r_rsp_lt;
    assign bus.rsp_ltu   = r_rsp_ltu;

endmodule

`default_nettype wire

// File: tb/tb_alu_arbiter.sv
//------------------------------------------------------------------------------
// Module : tb_alu_arbiter
// Directed scoreboard bench for alu_arbiter with a behavioural ALU.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_alu_arbiter;
    localparam int NUM_REQ = 2;

    typedef struct packed {
        logic [0:0]  id;
        logic [31:0] data;
        logic        z;
        logic        lt;
        logic        ltu;
    } rsp_t;

    logic clk;
    logic rst_n;
    int   tests;
    int   fails;
    rsp_t sbq[$];

    alu_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

    alu_arbiter #(.NUM_REQ(NUM_REQ)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Opcodes: 0 add, 1 sub, 2 and, 3 or, 4 xor, 5 sra, 6 sll, 7 srl
    always_comb begin
        case (bus.alu_op)
            3'd0:    bus.alu_out = bus.alu_in1 + bus.alu_in2;
            3'd1:    bus.alu_out = bus.alu_in1 - bus.alu_in2;
            3'd2:    bus.alu_out = bus.alu_in1 & bus.alu_in2;
            3'd3:    bus.alu_out = bus.alu_in1 | bus.alu_in2;
            3'd4:    bus.alu_out = bus.alu_in1 ^ bus.alu_in2;
            3'd5:    bus.alu_out = $unsigned($signed(bus.alu_in1) >>> bus.alu_in2[4:0]);
            3'd6:    bus.alu_out = bus.alu_in1 << bus.alu_in2[4:0];
            default: bus.alu_out = bus.alu_in1 >> bus.alu_in2[4:0];
        endcase
        bus.zero               = (bus.alu_out == 32'd0);
        bus.less_than          = ($signed(bus.alu_in1) < $signed(bus.alu_in2));
        bus.less_than_unsigned = (bus.alu_in1 < bus.alu_in2);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.req_op[3*i +: 3]   = op;
        bus.req_in1[32*i +: 32] = a;
        bus.req_in2[32*i +: 32] = b;
    endtask

    task automatic push(input logic [0:0] id, input logic [31:0] d, input logic z, input logic lt, input logic ltu);
        rsp_t e;
        e.id = id; e.data = d; e.z = z; e.lt = lt; e.ltu = ltu;
        sbq.push_back(e);
    endtask

    // Requester 0 alone: check its grant, record the expected response, advance
    task automatic issue0(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] d, input logic z, input logic lt, input logic ltu,
                          input string name);
        set_req(0, op, a, b);
        bus.req_valid = 2'b01;
        #1;
        chk(name, 32'(bus.req_ready), 32'h1);
        push(1'b0, d, z, lt, ltu);
        cycle();
    endtask

    // Monitor: a response is consumed when valid and ready coincide at the edge
    always @(negedge clk) begin
        if (bus.rsp_valid && bus.rsp_ready) begin
            tests++;
            if (sbq.size() == 0) begin
                fails++;
                $display("FAIL rsp_unexpected: got id=%0d data=%h, expected no response",
                         bus.rsp_id, bus.rsp_data);
            end else begin
                rsp_t e;
                rsp_t a;
                e = sbq.pop_front();
                a.id = bus.rsp_id; a.data = bus.rsp_data;
                a.z = bus.rsp_zero; a.lt = bus.rsp_lt; a.ltu = bus.rsp_ltu;
                if (a !== e) begin
                    fails++;
                    $display("FAIL rsp: got id=%0d data=%h z=%b lt=%b ltu=%b, expected id=%0d data=%h z=%b lt=%b ltu=%b",
                             a.id, a.data, a.z, a.lt, a.ltu, e.id, e.data, e.z, e.lt, e.ltu);
                end
            end
        end
    end

    initial begin
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        bus.req_valid = 2'b11;
        bus.req_in1 = '0;
        bus.req_in2 = '0;
        bus.req_op  = '0;
        bus.rsp_ready = 1'b1;
        set_req(0, 3'd0, 32'd10, 32'd20);
        set_req(1, 3'd0, 32'd5,  32'd7);

        // Reset with all requesters active
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_ready", 32'(bus.req_ready), 32'h0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
        chk("rst_rsp_id",    32'(bus.rsp_id),    32'h0);
        chk("rst_rsp_data",  bus.rsp_data,       32'h0);
        chk("rst_rsp_flags", {29'd0, bus.rsp_zero, bus.rsp_lt, bus.rsp_ltu}, 32'h0);
        chk("rst_alu_in1",   bus.alu_in1,        32'h0);
        chk("rst_alu_in2",   bus.alu_in2,        32'h0);
        chk("rst_alu_op",    32'(bus.alu_op),    32'h0);

        rst_n = 1'b1;
        #1;
        chk("first_grant", 32'(bus.req_ready), 32'h1);
        push(1'b0, 32'd30, 1'b0, 1'b1, 1'b1);
        cycle();
        bus.req_valid = 2'b00;

        // Single add from requester 1
        set_req(1, 3'd0, 32'd5, 32'd7);
        bus.req_valid = 2'b10;
        #1;
        chk("add_grant", 32'(bus.req_ready), 32'h2);
        chk("add_alu_in1", bus.alu_in1, 32'd5);
        push(1'b1, 32'd12, 1'b0, 1'b1, 1'b1);
        cycle();
        bus.req_valid = 2'b00;
        chk("add_rsp_valid", 32'(bus.rsp_valid), 32'h1);
        chk("add_rsp_id",    32'(bus.rsp_id),    32'h1);
        chk("add_rsp_data",  bus.rsp_data,       32'd12);

        // Fairness: both requesters continuously active
        set_req(0, 3'd0, 32'd1, 32'd1);
        set_req(1, 3'd1, 32'd9, 32'd4);
        bus.req_valid = 2'b11;
        for (int k = 0; k < 6; k++) begin
            #1;
            chk($sformatf("fair_grant%0d", k), 32'(bus.req_ready), (k % 2 == 0) ? 32'h1 : 32'h2);
            if (k % 2 == 0) push(1'b0, 32'd2, 1'b0, 1'b0, 1'b0);
            else            push(1'b1, 32'd5, 1'b0, 1'b0, 1'b0);
            cycle();
        end
        bus.req_valid = 2'b00;
        cycle();

        // Backpressure
        bus.rsp_ready = 1'b0;
        set_req(0, 3'd0, 32'd100, 32'd1);
        bus.req_valid = 2'b01;
        #1;
        chk("bp_first_grant", 32'(bus.req_ready), 32'h1);
        push(1'b0, 32'd101, 1'b0, 1'b0, 1'b0);
        cycle();
        set_req(1, 3'd0, 32'd3, 32'd4);
        bus.req_valid = 2'b10;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("bp_ready%0d", k), 32'(bus.req_ready), 32'h0);
            chk($sformatf("bp_data%0d", k),  bus.rsp_data,       32'd101);
            chk($sformatf("bp_valid%0d", k), {31'd0, bus.rsp_valid}, 32'h1);
            cycle();
        end
        bus.rsp_ready = 1'b1;
        #1;
        chk("bp_release_grant", 32'(bus.req_ready), 32'h2);
        push(1'b1, 32'd7, 1'b0, 1'b1, 1'b1);
        cycle();
        bus.req_valid = 2'b00;
        chk("bp_new_id",   32'(bus.rsp_id), 32'h1);
        chk("bp_new_data", bus.rsp_data,    32'd7);
        cycle();

        // Flags, back to back
        issue0(3'd1, 32'd3, 32'd3, 32'd0, 1'b1, 1'b0, 1'b0, "flag_sub_grant");
        issue0(3'd1, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFE, 1'b0, 1'b1, 1'b0, "flag_lt_grant");
        issue0(3'd5, 32'h8000_0000, 32'd4, 32'hF800_0000, 1'b0, 1'b1, 1'b0, "flag_sra_grant");
        bus.req_valid = 2'b00;
        cycle();
        cycle();

        // Reset while a response is stalled; ptr is 1 beforehand
        bus.rsp_ready = 1'b0;
        set_req(0, 3'd0, 32'd10, 32'd20);
        issue0(3'd0, 32'd10, 32'd20, 32'd30, 1'b0, 1'b1, 1'b1, "mid_grant");
        void'(sbq.pop_back());
        bus.req_valid = 2'b11;
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(bus.rsp_valid), 32'h0);
        chk("mid_rst_ready", 32'(bus.req_ready), 32'h0);
        cycle();
        rst_n = 1'b1;
        bus.rsp_ready = 1'b1;
        #1;
        chk("mid_rel_valid", 32'(bus.rsp_valid), 32'h0);
        chk("mid_rel_ptr0",  32'(bus.req_ready), 32'h1);
        push(1'b0, 32'd30, 1'b0, 1'b1, 1'b1);
        cycle();
        bus.req_valid = 2'b00;
        repeat (3) cycle();

        chk("sb_empty", 32'(sbq.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
